// File: rtl/iir_mc_pkg.sv
// iir_mc_pkg: shared coefficient-select enum and width helpers for the multi-channel IIR
package iir_mc_pkg;
  typedef enum logic [1:0] {COEF_B0, COEF_B1, COEF_A1, COEF_NONE} coef_sel_e;
  function automatic int ch_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int acc_width(input int data_w, input int coef_w, input int frac_w);
    return coef_w + data_w + frac_w + 2;
  endfunction
  function automatic int rs_width(input int in_w);
    return in_w + 1;
  endfunction
endpackage

// File: rtl/iir_mc_filter_if.sv
// iir_mc_filter_if: sample stream, result stream, coefficient write and state clear signals
interface iir_mc_filter_if #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 32,
  parameter int CHANNELS = 4
);
  import iir_mc_pkg::*;
  localparam int CH_W = ch_width(CHANNELS);
  logic in_valid, in_ready, in_bypass;
  logic [CH_W-1:0] in_ch;
  logic [DATA_W-1:0] in_data;
  logic out_valid;
  logic [CH_W-1:0] out_ch;
  logic [DATA_W-1:0] out_data;
  logic coef_we;
  logic [CH_W-1:0] coef_ch;
  coef_sel_e coef_sel;
  logic [COEF_W-1:0] coef_data;
  logic clr_en, clr_all;
  logic [CH_W-1:0] clr_ch;
  modport master (
    output in_valid, in_ch, in_data, in_bypass, coef_we, coef_ch, coef_sel, coef_data, clr_en, clr_all, clr_ch,
    input in_ready, out_valid, out_ch, out_data
  );
  modport slave (
    input in_valid, in_ch, in_data, in_bypass, coef_we, coef_ch, coef_sel, coef_data, clr_en, clr_all, clr_ch,
    output in_ready, out_valid, out_ch, out_data
  );
endinterface

// File: rtl/iir_round_sat.sv
// iir_round_sat: arithmetic right shift with optional round-half-up and signed saturation
module iir_round_sat #(
  parameter int IN_W = 66,
  parameter int SHIFT = 32,
  parameter int OUT_W = 16,
  parameter bit ROUND = 1'b1
) (
  input logic signed [IN_W-1:0] din,
  output logic signed [OUT_W-1:0] dout
);
  import iir_mc_pkg::*;
  localparam int W = rs_width(IN_W);
  localparam logic signed [W-1:0] RND = {{(W-SHIFT){1'b0}}, ROUND, {(SHIFT-1){1'b0}}};
  localparam logic signed [W-1:0] HI = {{(W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [W-1:0] LO = {{(W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  logic signed [W-1:0] sum, sh;
  // one spare bit keeps the rounding add from overflowing before the clamp
  always_comb begin
    sum = {din[IN_W-1], din} + RND;
    sh = sum >>> SHIFT;
    dout = sh > HI ? HI[OUT_W-1:0] : sh < LO ? LO[OUT_W-1:0] : sh[OUT_W-1:0];
  end
endmodule

// File: rtl/iir_mc_filter.sv
// iir_mc_filter: time-multiplexed first-order IIR over CHANNELS streams with round/saturate
module iir_mc_filter #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 32,
  parameter int FRAC_W = 16,
  parameter int CHANNELS = 4
) (
  input logic clk,
  input logic reset,
  iir_mc_filter_if.slave bus
);
  import iir_mc_pkg::*;
  localparam int CH_W = ch_width(CHANNELS);
  localparam int Y_W = DATA_W + FRAC_W;
  localparam int P0_W = COEF_W + DATA_W;
  localparam int P2_W = COEF_W + Y_W;
  localparam int ACC_W = acc_width(DATA_W, COEF_W, FRAC_W);
  logic signed [COEF_W-1:0] c0 [CHANNELS];
  logic signed [COEF_W-1:0] c1 [CHANNELS];
  logic signed [COEF_W-1:0] c2 [CHANNELS];
  logic signed [DATA_W-1:0] x1 [CHANNELS];
  logic signed [Y_W-1:0] y1 [CHANNELS];
  logic a_valid, a_bypass, a_in_range, b_valid, b_bypass;
  logic [CH_W-1:0] a_ch, a_idx, b_ch;
  logic signed [DATA_W-1:0] a_data, b_data, y_out;
  logic signed [P0_W-1:0] b_p0, b_p1;
  logic signed [P2_W-1:0] b_p2;
  logic signed [ACC_W-1:0] acc;
  logic signed [Y_W-1:0] y_next;
  assign bus.in_ready = !(a_valid && a_ch == bus.in_ch);
  assign a_in_range = int'(a_ch) < CHANNELS;
  assign a_idx = a_in_range ? a_ch : '0;
  assign acc = ((ACC_W'(b_p0) + ACC_W'(b_p1)) <<< FRAC_W) + ACC_W'(b_p2);
  iir_round_sat #(.IN_W(ACC_W), .SHIFT(2*FRAC_W), .OUT_W(DATA_W), .ROUND(1'b1)) u_out (.din(acc), .dout(y_out));
  iir_round_sat #(.IN_W(ACC_W), .SHIFT(FRAC_W), .OUT_W(Y_W), .ROUND(1'b0)) u_state (.din(acc), .dout(y_next));
  // stage A captures the sample; stage B forms products from the channel's live coefficients and state
  always_ff @(posedge clk) begin
    a_valid <= !reset && bus.in_valid && bus.in_ready;
    b_valid <= !reset && a_valid;
    if (bus.in_valid && bus.in_ready) begin
      a_ch <= bus.in_ch;
      a_data <= $signed(bus.in_data);
      a_bypass <= bus.in_bypass;
    end
    b_ch <= a_ch;
    b_data <= a_data;
    b_bypass <= a_bypass || !a_in_range;
    b_p0 <= P0_W'(c0[a_idx]) * P0_W'(a_data);
    b_p1 <= P0_W'(c1[a_idx]) * P0_W'(x1[a_idx]);
    b_p2 <= P2_W'(c2[a_idx]) * P2_W'(y1[a_idx]);
  end
  // result register: one pulse per sample, bypassed samples pass through untouched
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.out_ch <= '0;
      bus.out_data <= '0;
    end else begin
      bus.out_valid <= b_valid;
      if (b_valid) begin
        bus.out_ch <= b_ch;
        bus.out_data <= b_bypass ? b_data : y_out;
      end
    end
  end
  // coefficient banks; out-of-range channels and COEF_NONE match no entry
  always_ff @(posedge clk) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (reset) begin
        c0[i] <= '0;
        c1[i] <= '0;
        c2[i] <= '0;
      end else if (bus.coef_we && bus.coef_ch == CH_W'(i)) begin
        c0[i] <= bus.coef_sel == COEF_B0 ? $signed(bus.coef_data) : c0[i];
        c1[i] <= bus.coef_sel == COEF_B1 ? $signed(bus.coef_data) : c1[i];
        c2[i] <= bus.coef_sel == COEF_A1 ? $signed(bus.coef_data) : c2[i];
      end
    end
  end
  // per-channel history; a clear takes priority over a same-edge state write
  always_ff @(posedge clk) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (reset || (bus.clr_en && (bus.clr_all || bus.clr_ch == CH_W'(i)))) begin
        x1[i] <= '0;
        y1[i] <= '0;
      end else if (b_valid && !b_bypass && b_ch == CH_W'(i)) begin
        x1[i] <= b_data;
        y1[i] <= y_next;
      end
    end
  end
endmodule
